wlan_tx_controller: RTL and testbench
=====================================

// Module: wlan_tx_controller
// PURPOSE
//  IEEE 802.11a baseband TX bit-level controller: accepts RATE/LENGTH and a serial PSDU from the MAC.
//  Emits the coded PPDU bitstream (SIGNAL + DATA fields) serially at iClk rate to the downstream interleaver/mapper.
//  Internal /2 clock enable: input consumed at iClk/2, rate-1/2 coded output at iClk.
// PARAMETERS
//  SCR_SEED  7'b1011101  DATA-field scrambler initial state
//  DLY_BITS  40          input delay line depth; = 24 SIGNAL + 16 SERVICE slow ticks
// PORTS
//  iClk     in   1   system clock; the only clock
//  iRst     in   1   asynchronous, active-low reset
//  iStart   in   1   request; sampled on slow tick
//  iRate    in   4   802.11a RATE code R1..R4 = iRate[3:0]
//  iLength  in   12  PSDU length in octets
//  iData    in   1   serial PSDU bit, one per slow tick
//  oData    out  1   coded serial output bit
//  oTX_EN   out  1   high while oData carries valid PPDU bits
//  oBusy    out  1   high from start acceptance to last output bit
// BEHAVIOUR
//  - Reset (iRst=0, async): FSM=IDLE; oData=0, oTX_EN=0, oBusy=0.
//    Divider, scrambler, encoder and delay line are cleared.
//  - Slow tick: internal toggle slwClk1, rising every 2nd iClk after reset release.
//    All inputs are sampled only on slow ticks.
//  - Rate to N_DBPS map: D=24, F=36, 5=48, 7=72, 9=96, B=144, 1=192, 3=216.
//    An invalid code is treated as D (6 Mb/s), including in the SIGNAL field.
//  - IDLE: iStart=1 on tick T0 latches iRate/iLength, sets oBusy, and enters SIGNAL.
//    iStart is ignored outside IDLE.
//  - PSDU bit k is sampled on tick T0+1+k, k=0..8*L-1; host order is MSB of each octet first.
//  - Each input bit enters a DLY_BITS-stage shift line; its output feeds the DATA path at tick T0+41+k.
//  - SIGNAL field, 24 bits, unscrambled, sent in this order:
//      RATE iRate[3] first; reserved 0; LENGTH LSB first;
//      even parity over those 17 bits; 6 zero tail bits.
//  - DATA field bits: 16 zero SERVICE, then PSDU, then 6 tail, then pad zeros.
//    N_SYM = ceil((22+8L)/N_DBPS); total = N_SYM*N_DBPS.
//  - Scrambler: x^7+x^4+1 seeded with SCR_SEED at DATA start.
//    Applied to SERVICE, PSDU and pad; the 6 tail bits are forced to 0 after scrambling.
//  - Convolutional encoder: K=7, g0=133o, g1=171o, state zeroed at SIGNAL start.
//    Runs continuously into DATA. Each source bit yields A (g0) then B (g1) on consecutive iClk cycles.
//  - oTX_EN rises with the first A bit, 2 iClk after T0.
//    It stays high exactly 48 + 2*N_SYM*N_DBPS cycles with no gaps.
//  - oData is registered and is 0 whenever oTX_EN=0.
//  - End of burst: oTX_EN and oBusy fall together after the last B bit; FSM returns to IDLE.
//    A new iStart is accepted on the next slow tick.
//  - iLength=0: valid; DATA = SERVICE + tail + pad, N_SYM=1.
//  - Bits presented on iData beyond 8L ticks are ignored.
//  - Reset mid-burst aborts immediately; no partial flush.
//  - FSM: IDLE -> SIGNAL (24 ticks) -> DATA (N_SYM*N_DBPS ticks) -> IDLE.
// CONFIGURATION
//  SCRAMBLER_EN defined: DATA scrambled as above.
//  SCRAMBLER_EN undefined: scrambler bypassed (raw SERVICE/PSDU/pad); tail and all timing unchanged.
// TESTING
//  1. Reset: hold iRst=0 for 2 cycles -> oData=0, oTX_EN=0, oBusy=0; release -> outputs stay 0.
//  2. Rate=D, L=0 -> 96 oTX_EN cycles (48 SIGNAL + 48 DATA).
//     First 48 bits equal the encoded SIGNAL 1101_0_000000000000_1_000000.
//  3. Rate=D, L=10, bytes 00..09 -> N_SYM=5, oTX_EN high 288 cycles.
//     Output must match the golden model bit-for-bit.
//  4. Rate=3 (54M), L=100 -> N_SYM=4, 48+1728=1776 oTX_EN cycles; oBusy falls with oTX_EN.
//  5. iStart pulsed mid-burst -> ignored, burst length unchanged.
//     Back-to-back start on the first tick after idle -> accepted.
//  6. iRst=0 mid-DATA -> outputs 0 within the same cycle.
//     A restart after release reproduces the scenario-3 stream exactly.

Source files
------------

// File: rtl/wlan_tx_controller.sv
// wlan_tx_controller
// 802.11a baseband TX bit-level controller. It takes RATE/LENGTH and a serial
// PSDU from the MAC. It emits the rate-1/2 coded SIGNAL + DATA bitstream serially,
// one coded bit per iClk.
// Source bits are consumed on an internal /2 slow tick. Each source bit gives A (g0)
// on the tick edge and B (g1) on the following edge.
// Optional feature macro: SCRAMBLER_EN. When it is defined, the DATA field is scrambled.
// When it is undefined, the scrambler is bypassed and timing and tail are unchanged.
//
// state  | meaning
// IDLE   | waiting for iStart on a slow tick; outputs low
// SIGNAL | 24 SIGNAL-field source bits, unscrambled
// DATA   | SERVICE, PSDU, tail, pad source bits (N_SYM*N_DBPS ticks)
// FLUSH  | last B bit on the wire; TX_EN and busy drop on the next tick
module wlan_tx_controller #(
    parameter logic [6:0]  SCR_SEED = 7'b1011101,
    parameter int unsigned DLY_BITS = 40
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic        iStart,
    input  logic [3:0]  iRate,
    input  logic [11:0] iLength,
    input  logic        iData,
    output logic        oData,
    output logic        oTX_EN,
    output logic        oBusy
);

    typedef enum logic [1:0] {ST_IDLE, ST_SIGNAL, ST_DATA, ST_FLUSH} state_t;

    state_t              state;
    logic                slwClk1;
    logic                tick;
    logic [DLY_BITS-1:0] dly_line;
    logic                dly_out;

    logic [3:0]  rate_q;
    logic [11:0] len_q;
    logic [7:0]  ndbps_q;
    logic [4:0]  sig_idx;
    logic [15:0] data_idx;
    logic [7:0]  sym_cnt;
    logic [6:0]  scr;
    logic [5:0]  enc_sr;
    logic        b_hold;

    logic [7:0]  ndbps_in;
    logic [3:0]  rate_eff_in;
    logic [31:0] sig_vec;
    logic [15:0] psdu_end;
    logic [15:0] tail_end;
    logic        in_psdu;
    logic        in_tail;
    logic        scr_fb;
    logic        data_raw;
    logic        data_scr;
    logic        data_bit;
    logic        src_bit;
    logic        enc_a;
    logic        enc_b;

    // N_DBPS for each legal RATE code; 0 marks an illegal code
    function automatic logic [7:0] ndbps_of(input logic [3:0] r);
        logic [7:0] n;
        case (r)
            4'hD:    n = 8'd24;
            4'hF:    n = 8'd36;
            4'h5:    n = 8'd48;
            4'h7:    n = 8'd72;
            4'h9:    n = 8'd96;
            4'hB:    n = 8'd144;
            4'h1:    n = 8'd192;
            4'h3:    n = 8'd216;
            default: n = 8'd0;
        endcase
        return n;
    endfunction

    assign tick    = slwClk1;
    assign dly_out = dly_line[DLY_BITS-1];

    // slow-tick divider: a tick edge is every second iClk after reset release
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            slwClk1 <= 1'b0;
        end else begin
            slwClk1 <= ~slwClk1;
        end
    end

    // input delay line covering SIGNAL + SERVICE, shifted once per slow tick
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            dly_line <= '0;
        end else if (tick) begin
            dly_line <= {dly_line[DLY_BITS-2:0], iData};
        end
    end

    // rate decode at request time; illegal codes fall back to 6 Mb/s
    always_comb begin
        rate_eff_in = iRate;
        ndbps_in    = ndbps_of(iRate);
        if (ndbps_in == 8'd0) begin
            rate_eff_in = 4'hD;
            ndbps_in    = 8'd24;
        end
    end

    // SIGNAL word in transmit order: bit i of sig_vec is the i-th bit sent
    always_comb begin
        sig_vec     = '0;
        sig_vec[0]  = rate_q[3];
        sig_vec[1]  = rate_q[2];
        sig_vec[2]  = rate_q[1];
        sig_vec[3]  = rate_q[0];
        sig_vec[4]  = 1'b0;
        for (int i = 0; i < 12; i++) begin
            sig_vec[5+i] = len_q[i];
        end
        sig_vec[17] = ^{rate_q, len_q};
    end

    // source-bit selection, scrambling and K=7 encoder taps (enc_sr[0] is newest)
    always_comb begin
        psdu_end = 16'd16 + {1'b0, len_q, 3'b000};
        tail_end = psdu_end + 16'd6;
        in_psdu  = (data_idx >= 16'd16) && (data_idx < psdu_end);
        in_tail  = (data_idx >= psdu_end) && (data_idx < tail_end);
        scr_fb   = scr[6] ^ scr[3];
        data_raw = in_psdu ? dly_out : 1'b0;
`ifdef SCRAMBLER_EN
        data_scr = data_raw ^ scr_fb;
`else
        data_scr = data_raw;
`endif
        data_bit = in_tail ? 1'b0 : data_scr;
        src_bit  = (state == ST_DATA) ? data_bit : sig_vec[sig_idx];
        enc_a    = src_bit ^ enc_sr[1] ^ enc_sr[2] ^ enc_sr[4] ^ enc_sr[5];
        enc_b    = src_bit ^ enc_sr[0] ^ enc_sr[1] ^ enc_sr[2] ^ enc_sr[5];
    end

    // main sequencer: FSM, field counters, scrambler, encoder state and registered outputs
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            state    <= ST_IDLE;
            rate_q   <= 4'hD;
            len_q    <= '0;
            ndbps_q  <= 8'd24;
            sig_idx  <= '0;
            data_idx <= '0;
            sym_cnt  <= '0;
            scr      <= SCR_SEED;
            enc_sr   <= '0;
            b_hold   <= 1'b0;
            oData    <= 1'b0;
            oTX_EN   <= 1'b0;
            oBusy    <= 1'b0;
        end else if (tick) begin
            case (state)
                ST_IDLE: begin
                    oData  <= 1'b0;
                    oTX_EN <= 1'b0;
                    oBusy  <= 1'b0;
                    if (iStart) begin
                        rate_q  <= rate_eff_in;
                        len_q   <= iLength;
                        ndbps_q <= ndbps_in;
                        sig_idx <= '0;
                        enc_sr  <= '0;
                        oBusy   <= 1'b1;
                        state   <= ST_SIGNAL;
                    end
                end
                ST_SIGNAL: begin
                    oData  <= enc_a;
                    b_hold <= enc_b;
                    oTX_EN <= 1'b1;
                    enc_sr <= {enc_sr[4:0], src_bit};
                    if (sig_idx == 5'd23) begin
                        data_idx <= '0;
                        sym_cnt  <= ndbps_q - 8'd1;
                        scr      <= SCR_SEED;
                        state    <= ST_DATA;
                    end else begin
                        sig_idx <= sig_idx + 5'd1;
                    end
                end
                ST_DATA: begin
                    oData    <= enc_a;
                    b_hold   <= enc_b;
                    oTX_EN   <= 1'b1;
                    enc_sr   <= {enc_sr[4:0], src_bit};
                    scr      <= {scr[5:0], scr_fb};
                    data_idx <= data_idx + 16'd1;
                    // burst ends on the first symbol boundary that covers SERVICE+PSDU+tail
                    if (sym_cnt == 8'd0) begin
                        if (data_idx >= tail_end - 16'd1) begin
                            state <= ST_FLUSH;
                        end else begin
                            sym_cnt <= ndbps_q - 8'd1;
                        end
                    end else begin
                        sym_cnt <= sym_cnt - 8'd1;
                    end
                end
                ST_FLUSH: begin
                    oData  <= 1'b0;
                    oTX_EN <= 1'b0;
                    oBusy  <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    oData  <= 1'b0;
                    oTX_EN <= 1'b0;
                    oBusy  <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end else if (oTX_EN) begin
            oData <= b_hold;
        end
    end

endmodule

// File: tb/tb_wlan_tx_controller.sv
// Testbench for wlan_tx_controller. A reference model builds the expected coded
// PPDU from the 802.11a field rules. The bench compares every output cycle of each burst.
module tb_wlan_tx_controller;

    logic        iClk = 1'b0;
    logic        iRst = 1'b1;
    logic        iStart = 1'b0;
    logic [3:0]  iRate = 4'h0;
    logic [11:0] iLength = '0;
    logic        iData = 1'b0;
    logic        oData;
    logic        oTX_EN;
    logic        oBusy;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    byte unsigned psdu [0:4095];
    bit          exp_q [$];

    localparam logic [6:0] SEED = 7'b1011101;
    localparam logic [6:0] G0   = 7'o133;
    localparam logic [6:0] G1   = 7'o171;

    wlan_tx_controller dut (
        .iClk    (iClk),
        .iRst    (iRst),
        .iStart  (iStart),
        .iRate   (iRate),
        .iLength (iLength),
        .iData   (iData),
        .oData   (oData),
        .oTX_EN  (oTX_EN),
        .oBusy   (oBusy)
    );

    always #5 iClk = ~iClk;

    // edges since reset release; a slow tick edge follows whenever cyc is odd
    always @(posedge iClk or negedge iRst) begin
        if (!iRst) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic obs, input logic exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
        end
    endtask

    // expected coded bits of a whole PPDU, from the field rules
    task automatic build_model(input logic [3:0] rate, input int len);
        int          nd;
        logic [3:0]  re;
        logic [11:0] lv;
        bit          src [$];
        bit          sq [];
        int          nsym;
        int          total;
        bit          a;
        bit          b;
        case (rate)
            4'hD: nd = 24;   4'hF: nd = 36;   4'h5: nd = 48;   4'h7: nd = 72;
            4'h9: nd = 96;   4'hB: nd = 144;  4'h1: nd = 192;  4'h3: nd = 216;
            default: nd = 0;
        endcase
        re = rate;
        if (nd == 0) begin
            re = 4'hD;
            nd = 24;
        end
        lv = 12'(len);
        src = {};
        for (int i = 3; i >= 0; i--) src.push_back(re[i]);
        src.push_back(1'b0);
        for (int i = 0; i < 12; i++) src.push_back(lv[i]);
        src.push_back(^{re, lv});
        repeat (6) src.push_back(1'b0);
        nsym  = (22 + 8 * len + nd - 1) / nd;
        total = nsym * nd;
        // scrambler sequence: s[n] = s[n-7] ^ s[n-4], s[-k] = seed bit k-1, stored at sq[n+7]
        sq = new[total + 7];
        for (int k = 1; k <= 7; k++) sq[7-k] = SEED[k-1];
        for (int i = 7; i < total + 7; i++) sq[i] = sq[i-7] ^ sq[i-4];
        for (int d = 0; d < total; d++) begin
            bit v;
            v = 1'b0;
            if (d >= 16 && d < 16 + 8 * len) v = psdu[(d-16)/8][7-((d-16)%8)];
`ifdef SCRAMBLER_EN
            v = v ^ sq[d+7];
`endif
            if (d >= 16 + 8 * len && d < 22 + 8 * len) v = 1'b0;
            src.push_back(v);
        end
        exp_q = {};
        for (int j = 0; j < src.size(); j++) begin
            a = 1'b0;
            b = 1'b0;
            for (int t = 0; t < 7; t++) begin
                if (j - t >= 0) begin
                    if (G0[6-t] == 1'b1) a = a ^ src[j-t];
                    if (G1[6-t] == 1'b1) b = b ^ src[j-t];
                end
            end
            exp_q.push_back(a);
            exp_q.push_back(b);
        end
    endtask

    function automatic logic psdu_bit(input int k, input int len);
        if (k < 8 * len) return psdu[k/8][7-(k%8)];
        return 1'($urandom_range(0, 1));
    endfunction

    // one burst; c counts edges after the accepting tick T0, sampled at negedge
    task automatic run_burst(input logic [3:0] rate, input int len, input int pulse_c,
                             input int abort_c, input string tag);
        int c_end;
        build_model(rate, len);
        c_end = 2 + exp_q.size();
        if (cyc % 2 == 0) @(negedge iClk);
        iRate   = rate;
        iLength = 12'(len);
        iStart  = 1'b1;
        for (int c = 0; c <= c_end + 1; c++) begin
            @(negedge iClk);
            if (c == 0) iStart = 1'b0;
            if (c == abort_c) begin
                iRst = 1'b0;
                #1;
                chk({tag, " abort oData"}, oData, 1'b0);
                chk({tag, " abort oTX_EN"}, oTX_EN, 1'b0);
                chk({tag, " abort oBusy"}, oBusy, 1'b0);
                repeat (2) @(negedge iClk);
                iRst = 1'b1;
                return;
            end
            chk($sformatf("%s c=%0d oTX_EN", tag, c), oTX_EN, (c >= 2 && c < c_end));
            chk($sformatf("%s c=%0d oBusy", tag, c), oBusy, (c < c_end));
            chk($sformatf("%s c=%0d oData", tag, c), oData,
                (c >= 2 && c < c_end) ? exp_q[c-2] : 1'b0);
            if (c == pulse_c)     iStart = 1'b1;
            if (c == pulse_c + 2) iStart = 1'b0;
            if (c % 2 == 0) iData = psdu_bit(c / 2, len);
        end
    endtask

    initial begin
        int len;
        logic [3:0] rate;

        // reset held two cycles, then released with outputs still low
        #2 iRst = 1'b0;
        repeat (2) @(negedge iClk);
        chk("reset oData", oData, 1'b0);
        chk("reset oTX_EN", oTX_EN, 1'b0);
        chk("reset oBusy", oBusy, 1'b0);
        iRst = 1'b1;
        repeat (4) begin
            @(negedge iClk);
            chk("post-reset oData", oData, 1'b0);
            chk("post-reset oTX_EN", oTX_EN, 1'b0);
            chk("post-reset oBusy", oBusy, 1'b0);
        end

        // 6 Mb/s, empty PSDU
        run_burst(4'hD, 0, -1, -1, "rateD_L0");

        // 6 Mb/s, bytes 00..09, with an ignored start pulse mid-burst
        for (int i = 0; i < 10; i++) psdu[i] = 8'(i);
        run_burst(4'hD, 10, 101, -1, "rateD_L10");

        // 54 Mb/s, 100 random bytes, then a back-to-back empty burst
        for (int i = 0; i < 100; i++) psdu[i] = 8'($urandom_range(0, 255));
        run_burst(4'h3, 100, 700, -1, "rate3_L100");
        run_burst(4'hD, 0, -1, -1, "b2b_L0");

        // reset in the DATA field, then a full repeat of the 00..09 burst
        for (int i = 0; i < 10; i++) psdu[i] = 8'(i);
        run_burst(4'hD, 10, -1, 150, "abort");
        run_burst(4'hD, 10, -1, -1, "restart");

        // random rates (illegal codes included), lengths and payloads
        for (int n = 0; n < 8; n++) begin
            rate = 4'($urandom_range(0, 15));
            len  = $urandom_range(0, 60);
            for (int i = 0; i < len; i++) psdu[i] = 8'($urandom_range(0, 255));
            run_burst(rate, len, (n % 2 == 0) ? 61 : -1, -1, $sformatf("rnd%0d_r%h_L%0d", n, rate, len));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
